// File: rtl/cmd_pkt_pkg.sv
// ----------------------------------------------------------------------------
// cmd_pkt_pkg: shared types, constants and checksum helper for cmd_pkt_asm.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package cmd_pkt_pkg;

  localparam int BYTE_W         = 8;
  localparam int MAX_DATA_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHK     = 2'd2
  } pkt_state_e;

  // Unused upper payload bytes are zero, so they do not disturb the sum.
  function automatic logic [BYTE_W-1:0] pkt_chk(
    input logic [BYTE_W-1:0]                cmd,
    input logic [BYTE_W*MAX_DATA_BYTES-1:0] payload
  );
    logic [BYTE_W-1:0] sum;
    sum = cmd;
    for (int i = 0; i < MAX_DATA_BYTES; i++) begin
      sum = sum + payload[i*BYTE_W +: BYTE_W];
    end
    return ~sum;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cmd_pkt_asm_if.sv
// ----------------------------------------------------------------------------
// cmd_pkt_asm_if: UART byte input and cmd_cfg frame output of cmd_pkt_asm.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface cmd_pkt_asm_if #(
  parameter int DATA_BYTES = 2
);
  import cmd_pkt_pkg::*;

  logic [BYTE_W-1:0]            rx_data;
  logic                         rx_rdy;
  logic                         clr_rx_rdy;
  logic [BYTE_W-1:0]            cmd;
  logic [BYTE_W*DATA_BYTES-1:0] data;
  logic                         cmd_rdy;
  logic                         clr_cmd_rdy;
  logic                         frm_err;
  logic                         ovfl;

  modport master (
    output rx_data, rx_rdy, clr_cmd_rdy,
    input  clr_rx_rdy, cmd, data, cmd_rdy, frm_err, ovfl
  );

  modport slave (
    input  rx_data, rx_rdy, clr_cmd_rdy,
    output clr_rx_rdy, cmd, data, cmd_rdy, frm_err, ovfl
  );

endinterface

`default_nettype wire

// File: rtl/cmd_pkt_fifo.sv
// ----------------------------------------------------------------------------
// cmd_pkt_fifo: synchronous FIFO with wrap-bit pointers and same-cycle push/pop.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module cmd_pkt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_ok;
  logic             rd_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cmd_pkt_asm.sv
// ----------------------------------------------------------------------------
// cmd_pkt_asm: assembles cmd + DATA_BYTES payload frames into a frame FIFO.
// Rev 1.0 - optional trailing checksum byte via CMD_PKT_CHKSUM_EN
// ----------------------------------------------------------------------------
`default_nettype none

module cmd_pkt_asm
  import cmd_pkt_pkg::*;
#(
  parameter int DATA_BYTES = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TMO_CYCLES = 1_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  cmd_pkt_asm_if.slave bus
);

  localparam int PAY_W = BYTE_W * DATA_BYTES;
  localparam int FRM_W = BYTE_W + PAY_W;
  localparam int IDX_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int TMO_W = $clog2(TMO_CYCLES + 1);
  localparam int CHK_W = BYTE_W * MAX_DATA_BYTES;

  pkt_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [BYTE_W-1:0] cmd_byte_q, cmd_byte_d;
  logic [PAY_W-1:0]  payload_q, payload_d;
  logic [FRM_W-1:0]  hold_q, hold_d;
  logic              frm_err_q, frm_err_d;
  logic              ovfl_q, ovfl_d;

  logic [PAY_W-1:0]  payload_shift;
  logic [FRM_W-1:0]  push_frame;
  logic [FRM_W-1:0]  fifo_rdata;
  logic [FRM_W-1:0]  head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              tmo_expired;
  logic              last_byte;
  logic              push;
  logic              pop;
  logic              chk_bad;

  assign tmo_expired = (state_q != ST_IDLE) && (tmo_q == TMO_W'(TMO_CYCLES));
  assign last_byte   = (idx_q == IDX_W'(DATA_BYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Timeout is checked before the byte so an expiring frame swallows it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.rx_rdy) state_d = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (tmo_expired) begin
          state_d = ST_IDLE;
        end else if (bus.rx_rdy && last_byte) begin
`ifdef CMD_PKT_CHKSUM_EN
          state_d = ST_CHK;
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef CMD_PKT_CHKSUM_EN
      ST_CHK: begin
        if (tmo_expired || bus.rx_rdy) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_byte_d    = cmd_byte_q;
    payload_d     = payload_q;
    idx_d         = idx_q;
    tmo_d         = tmo_q;
    push          = 1'b0;
    chk_bad       = 1'b0;
    payload_shift = payload_q << BYTE_W;
    payload_shift[BYTE_W-1:0] = bus.rx_data;
    push_frame    = {cmd_byte_q, payload_shift};

    case (state_q)
      ST_IDLE: begin
        if (bus.rx_rdy) begin
          cmd_byte_d = bus.rx_data;
          payload_d  = '0;
          idx_d      = '0;
          tmo_d      = '0;
        end
      end
      ST_PAYLOAD: begin
        if (tmo_expired) begin
          tmo_d = '0;
        end else if (bus.rx_rdy) begin
          payload_d = payload_shift;
          idx_d     = idx_q + IDX_W'(1);
          tmo_d     = '0;
`ifndef CMD_PKT_CHKSUM_EN
          push      = last_byte;
`endif
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
`ifdef CMD_PKT_CHKSUM_EN
      ST_CHK: begin
        push_frame = {cmd_byte_q, payload_q};
        if (tmo_expired) begin
          tmo_d = '0;
        end else if (bus.rx_rdy) begin
          tmo_d = '0;
          if (bus.rx_data == pkt_chk(cmd_byte_q, CHK_W'(payload_q))) begin
            push = 1'b1;
          end else begin
            chk_bad = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
`endif
      default: ;
    endcase

    pop       = bus.clr_cmd_rdy && !fifo_empty;
    frm_err_d = tmo_expired || chk_bad;
    ovfl_d    = push && fifo_full && !pop;
    hold_d    = fifo_empty ? hold_q : fifo_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      tmo_q      <= '0;
      cmd_byte_q <= '0;
      payload_q  <= '0;
      hold_q     <= '0;
      frm_err_q  <= 1'b0;
      ovfl_q     <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      cmd_byte_q <= cmd_byte_d;
      payload_q  <= payload_d;
      hold_q     <= hold_d;
      frm_err_q  <= frm_err_d;
      ovfl_q     <= ovfl_d;
    end
  end

  cmd_pkt_fifo #(
    .WIDTH (FRM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (push),
    .wdata (push_frame),
    .rd_en (bus.clr_cmd_rdy),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // While empty the last popped head stays visible to cmd_cfg.
  assign head           = fifo_empty ? hold_q : fifo_rdata;
  assign bus.cmd        = head[FRM_W-1 -: BYTE_W];
  assign bus.data       = head[PAY_W-1:0];
  assign bus.cmd_rdy    = !fifo_empty;
  assign bus.clr_rx_rdy = bus.rx_rdy;
  assign bus.frm_err    = frm_err_q;
  assign bus.ovfl       = ovfl_q;

endmodule

`default_nettype wire

// File: tb/tb_cmd_pkt_asm.sv
// ----------------------------------------------------------------------------
// tb_cmd_pkt_asm: directed tables, corner sequences and randomized model check.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_cmd_pkt_asm;

  localparam int DB    = 2;
  localparam int DEPTH = 4;
  localparam int TMO   = 100;
`ifdef CMD_PKT_CHKSUM_EN
  localparam int FLEN  = DB + 2;
`else
  localparam int FLEN  = DB + 1;
`endif

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic rst4_n = 1'b0;

  always #5 clk = ~clk;

  cmd_pkt_asm_if #(.DATA_BYTES(DB)) bus2 ();
  cmd_pkt_asm_if #(.DATA_BYTES(4))  bus4 ();

  cmd_pkt_asm #(.DATA_BYTES(DB), .FIFO_DEPTH(DEPTH), .TMO_CYCLES(TMO)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  cmd_pkt_asm #(.DATA_BYTES(4), .FIFO_DEPTH(DEPTH), .TMO_CYCLES(TMO)) dut4 (
    .clk   (clk),
    .rst_n (rst4_n),
    .bus   (bus4)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: frames as byte queues, FIFO as a queue of {cmd,data}.
  logic [7:0]  part[$];
  logic [23:0] fq[$];
  int          gap = 0;
  logic [23:0] hold = '0;
  bit          m_fe = 0;
  bit          m_ov = 0;

  task automatic model_step(input bit rdy, input logic [7:0] d, input bit clr);
    logic [23:0] f;
    logic [7:0]  s;
    bit          ok;
    m_fe = 0;
    m_ov = 0;
    if (clr && fq.size() > 0) void'(fq.pop_front());
    if (part.size() > 0 && gap == TMO) begin
      part.delete();
      gap  = 0;
      m_fe = 1;
    end else if (rdy) begin
      part.push_back(d);
      gap = 0;
      if (part.size() == FLEN) begin
        f = '0;
        s = '0;
        for (int i = 0; i < DB + 1; i++) begin
          f = (f << 8) | 24'(part[i]);
          s = s + part[i];
        end
        ok = (FLEN == DB + 1) || (part[FLEN-1] == ~s);
        if (!ok) m_fe = 1;
        else if (fq.size() < DEPTH) fq.push_back(f);
        else m_ov = 1;
        part.delete();
      end
    end else if (part.size() > 0) begin
      gap++;
    end
    if (fq.size() > 0) hold = fq[0];
  endtask

  task automatic tick(input bit rdy, input logic [7:0] d, input bit clr);
    bus2.rx_rdy      = rdy;
    bus2.rx_data     = d;
    bus2.clr_cmd_rdy = clr;
    #1;
    chk("clr_rx_rdy", 32'(bus2.clr_rx_rdy), 32'(rdy));
    @(posedge clk);
    model_step(rdy, d, clr);
    #1;
    chk("m_cmd_rdy", 32'(bus2.cmd_rdy), 32'(fq.size() > 0));
    chk("m_cmd",     32'(bus2.cmd),     32'(hold[23:16]));
    chk("m_data",    32'(bus2.data),    32'(hold[15:0]));
    chk("m_frm_err", 32'(bus2.frm_err), 32'(m_fe));
    chk("m_ovfl",    32'(bus2.ovfl),    32'(m_ov));
  endtask

  function automatic logic [7:0] sum_chk(input logic [7:0] b []);
    logic [7:0] s;
    s = '0;
    foreach (b[i]) s = s + b[i];
    return ~s;
  endfunction

  task automatic send_frame(input logic [7:0] c, input logic [15:0] p);
    tick(1, c, 0);
    tick(1, p[15:8], 0);
    tick(1, p[7:0], 0);
`ifdef CMD_PKT_CHKSUM_EN
    tick(1, sum_chk('{c, p[15:8], p[7:0]}), 0);
`endif
  endtask

  task automatic send4(input logic [7:0] b);
    bus4.rx_rdy  = 1'b1;
    bus4.rx_data = b;
    @(posedge clk);
    #1;
    bus4.rx_rdy  = 1'b0;
  endtask

  typedef struct {
    bit          rdy;
    logic [7:0]  d;
    bit          clr;
    bit          e_rdy;
    logic [7:0]  e_cmd;
    logic [15:0] e_data;
    bit          e_fe;
    bit          e_ov;
  } vec_t;

  vec_t tbl[$];

  task automatic add_row(input bit rdy, input logic [7:0] d, input bit clr, input bit e_rdy,
                         input logic [7:0] e_cmd, input logic [15:0] e_data,
                         input bit e_fe, input bit e_ov);
    vec_t v;
    v.rdy = rdy; v.d = d; v.clr = clr; v.e_rdy = e_rdy;
    v.e_cmd = e_cmd; v.e_data = e_data; v.e_fe = e_fe; v.e_ov = e_ov;
    tbl.push_back(v);
  endtask

  // Frame k carries bytes k, 0x10+k, 0x20+k.
  function automatic logic [7:0] fb(input int k, input int b);
    if (b == 0) return 8'(k);
    if (b == 1) return 8'(8'h10 + k);
    return 8'(8'h20 + k);
  endfunction

  function automatic logic [15:0] fp(input int k);
    return {fb(k, 1), fb(k, 2)};
  endfunction

  initial begin
    bus2.rx_rdy = 1'b0; bus2.rx_data = '0; bus2.clr_cmd_rdy = 1'b0;
    bus4.rx_rdy = 1'b0; bus4.rx_data = '0; bus4.clr_cmd_rdy = 1'b0;

`ifndef CMD_PKT_CHKSUM_EN
    add_row(1, 8'h02, 0, 0, 8'h00, 16'h0000, 0, 0);
    add_row(1, 8'h12, 0, 0, 8'h00, 16'h0000, 0, 0);
    add_row(1, 8'h34, 0, 1, 8'h02, 16'h1234, 0, 0);
    add_row(0, 8'h00, 1, 0, 8'h02, 16'h1234, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      for (int b = 0; b < 3; b++) begin
        if (k == 1 && b < 2) add_row(1, fb(k, b), 0, 0, 8'h02, 16'h1234, 0, 0);
        else add_row(1, fb(k, b), 0, 1, 8'h01, fp(1), 0, (k == 5 && b == 2));
      end
    end
    for (int p = 1; p <= 4; p++) begin
      if (p < 4) add_row(0, 8'h00, 1, 1, fb(p + 1, 0), fp(p + 1), 0, 0);
      else       add_row(0, 8'h00, 1, 0, 8'h04, fp(4), 0, 0);
    end
    add_row(0, 8'h00, 1, 0, 8'h04, fp(4), 0, 0);
    for (int k = 6; k <= 10; k++) begin
      for (int b = 0; b < 3; b++) begin
        if (k == 6 && b < 2)        add_row(1, fb(k, b), 0, 0, 8'h04, fp(4), 0, 0);
        else if (k == 10 && b == 2) add_row(1, fb(k, b), 1, 1, fb(7, 0), fp(7), 0, 0);
        else                        add_row(1, fb(k, b), 0, 1, fb(6, 0), fp(6), 0, 0);
      end
    end
    for (int p = 1; p <= 4; p++) begin
      if (p < 4) add_row(0, 8'h00, 1, 1, fb(7 + p, 0), fp(7 + p), 0, 0);
      else       add_row(0, 8'h00, 1, 0, fb(10, 0), fp(10), 0, 0);
    end
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_rdy", 32'(bus2.cmd_rdy), 32'd0);
    chk("rst_cmd",     32'(bus2.cmd),     32'd0);
    chk("rst_data",    32'(bus2.data),    32'd0);
    chk("rst_frm_err", 32'(bus2.frm_err), 32'd0);
    chk("rst_ovfl",    32'(bus2.ovfl),    32'd0);
    chk("rst4_cmd_rdy", 32'(bus4.cmd_rdy), 32'd0);
    chk("rst4_data",    bus4.data,         32'd0);
    rst_n  = 1'b1;
    rst4_n = 1'b1;

    foreach (tbl[i]) begin
      tick(tbl[i].rdy, tbl[i].d, tbl[i].clr);
      chk($sformatf("tbl%0d_cmd_rdy", i), 32'(bus2.cmd_rdy), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_cmd", i),     32'(bus2.cmd),     32'(tbl[i].e_cmd));
      chk($sformatf("tbl%0d_data", i),    32'(bus2.data),    32'(tbl[i].e_data));
      chk($sformatf("tbl%0d_frm_err", i), 32'(bus2.frm_err), 32'(tbl[i].e_fe));
      chk($sformatf("tbl%0d_ovfl", i),    32'(bus2.ovfl),    32'(tbl[i].e_ov));
    end

`ifdef CMD_PKT_CHKSUM_EN
    tick(1, 8'h02, 0); tick(1, 8'h12, 0); tick(1, 8'h34, 0);
    chk("chk_wait", 32'(bus2.cmd_rdy), 32'd0);
    tick(1, 8'hB7, 0);
    chk("chk_ok_rdy",  32'(bus2.cmd_rdy), 32'd1);
    chk("chk_ok_data", 32'(bus2.data),    32'h1234);
    tick(0, 8'h00, 1);
    tick(1, 8'h02, 0); tick(1, 8'h12, 0); tick(1, 8'h34, 0); tick(1, 8'hB6, 0);
    chk("chk_bad_fe",  32'(bus2.frm_err), 32'd1);
    chk("chk_bad_rdy", 32'(bus2.cmd_rdy), 32'd0);
    tick(0, 8'h00, 0);
`endif

    // Timeout with idle line, then a clean frame.
    tick(1, 8'h02, 0);
    tick(1, 8'h12, 0);
    for (int i = 0; i < TMO; i++) begin
      tick(0, 8'h00, 0);
      chk("tmo_early", 32'(bus2.frm_err), 32'd0);
    end
    tick(0, 8'h00, 0);
    chk("tmo_pulse",   32'(bus2.frm_err), 32'd1);
    chk("tmo_no_rdy",  32'(bus2.cmd_rdy), 32'd0);
    tick(0, 8'h00, 0);
    chk("tmo_one_cyc", 32'(bus2.frm_err), 32'd0);
    send_frame(8'h03, 16'hABCD);
    chk("tmo_next_rdy",  32'(bus2.cmd_rdy), 32'd1);
    chk("tmo_next_cmd",  32'(bus2.cmd),     32'h03);
    chk("tmo_next_data", 32'(bus2.data),    32'hABCD);
    tick(0, 8'h00, 1);

    // Byte arriving on the expiry cycle is swallowed.
    tick(1, 8'h07, 0);
    for (int i = 0; i < TMO; i++) tick(0, 8'h00, 0);
    tick(1, 8'h99, 0);
    chk("coll_fe", 32'(bus2.frm_err), 32'd1);
    send_frame(8'h08, 16'h0102);
    chk("coll_cmd",  32'(bus2.cmd),  32'h08);
    chk("coll_data", 32'(bus2.data), 32'h0102);
    tick(0, 8'h00, 1);

    for (int seg = 0; seg < 10; seg++) begin
      int p;
      p = (seg % 3 == 0) ? 700 : ((seg % 3 == 1) ? 300 : 8);
      for (int i = 0; i < 300; i++) begin
        tick($urandom_range(0, 999) < p, 8'($urandom), $urandom_range(0, 3) == 0);
      end
    end
    tick(0, 8'h00, 0);

    // Four-byte payload, reset mid-frame, then the full frame again.
    send4(8'h05); send4(8'hDE); send4(8'hAD);
    rst4_n = 1'b0;
    #2;
    chk("r4_in_rst", 32'(bus4.cmd_rdy), 32'd0);
    rst4_n = 1'b1;
    #1;
    send4(8'h05); send4(8'hDE); send4(8'hAD); send4(8'hBE);
`ifdef CMD_PKT_CHKSUM_EN
    send4(8'hEF);
    chk("r4_lat", 32'(bus4.cmd_rdy), 32'd0);
    send4(8'hC2);
`else
    chk("r4_lat", 32'(bus4.cmd_rdy), 32'd0);
    send4(8'hEF);
`endif
    chk("r4_rdy",  32'(bus4.cmd_rdy), 32'd1);
    chk("r4_cmd",  32'(bus4.cmd),     32'h05);
    chk("r4_data", bus4.data,         32'hDEADBEEF);
    chk("r4_fe",   32'(bus4.frm_err), 32'd0);
    chk("r4_ovfl", 32'(bus4.ovfl),    32'd0);
    bus4.clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1;
    bus4.clr_cmd_rdy = 1'b0;
    chk("r4_pop_empty", 32'(bus4.cmd_rdy), 32'd0);
    chk("r4_hold",      bus4.data,         32'hDEADBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
